ungapped_extender: RTL and testbench

Scores one direction of an ungapped BLAST-N seed extension. Consumes the per-position nucleotide comparison result stream produced by the comparator stage, one position per cycle. Accumulates a running score from a seed score, tracks the best score and its extension length, and stops on X-drop, end of sequence, or maximum length. Presents one result record per extension to the hit-reporting logic via a valid/ready handshake.

---
 rtl/ungapped_extender.sv | 164 ++++++++++++++++
 tb/tb_ungapped_extender.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ungapped_extender.sv
// ---------------------------------------------------------------------------
// ungapped_extender : one-direction ungapped BLAST-N seed extension scorer.
// Optional macro UNGAPPED_EXT_AMBIG_EN: ambiguous query bases score zero.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ungapped_extender #(
  parameter int SCORE_W          = 16,
  parameter int LEN_W            = 10,
  parameter int MAX_LEN          = 1023,
  parameter int MATCH_SCORE      = 1,
  parameter int MISMATCH_PENALTY = 3,
  parameter int XDROP            = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [SCORE_W-1:0] seed_score,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         cmp_result,
  input  logic               in_last,
  output logic               busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SCORE_W-1:0] best_score,
  output logic [LEN_W-1:0]   best_len,
  output logic [1:0]         term_cause
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXTEND = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam logic signed [SCORE_W:0]   MATCH_D = (SCORE_W+1)'(MATCH_SCORE);
  localparam logic signed [SCORE_W:0]   PEN_D   = -((SCORE_W+1)'(MISMATCH_PENALTY));
  localparam logic signed [SCORE_W:0]   XDROP_D = (SCORE_W+1)'(XDROP);
  localparam logic [LEN_W-1:0]          MAX_LEN_D = LEN_W'(MAX_LEN);
  localparam logic [SCORE_W-1:0]        SAT_MAX = {1'b0, {(SCORE_W-1){1'b1}}};
  localparam logic [SCORE_W-1:0]        SAT_MIN = {1'b1, {(SCORE_W-1){1'b0}}};

  state_t state, state_nx;

  logic [SCORE_W-1:0]        cur;
  logic [LEN_W-1:0]          len;
  logic signed [SCORE_W:0]   delta;
  logic signed [SCORE_W:0]   sum;
  logic signed [SCORE_W:0]   diff;
  logic [SCORE_W-1:0]        cur_nx;
  logic [SCORE_W-1:0]        best_nx;
  logic [LEN_W-1:0]          best_len_nx;
  logic [LEN_W-1:0]          len_inc;
  logic                      xdrop_hit;
  logic                      max_hit;
  logic                      term;
  logic [1:0]                cause_nx;
  logic                      accept;

  assign accept  = in_valid && (state == EXTEND);
  assign len_inc = len + LEN_W'(1);

  always_comb begin
    delta = PEN_D;
    if (cmp_result == 3'b001) begin
      delta = MATCH_D;
    end
`ifdef UNGAPPED_EXT_AMBIG_EN
    else if (cmp_result[2]) begin
      delta = '0;
    end
`endif
    // One guard bit is enough to detect overflow of a single small step.
    sum = {cur[SCORE_W-1], cur} + delta;
    if (sum[SCORE_W] != sum[SCORE_W-1]) begin
      cur_nx = sum[SCORE_W] ? SAT_MIN : SAT_MAX;
    end else begin
      cur_nx = sum[SCORE_W-1:0];
    end
    if ($signed(cur_nx) > $signed(best_score)) begin
      best_nx     = cur_nx;
      best_len_nx = len_inc;
    end else begin
      best_nx     = best_score;
      best_len_nx = best_len;
    end
    diff      = {best_nx[SCORE_W-1], best_nx} - {cur_nx[SCORE_W-1], cur_nx};
    xdrop_hit = (diff > XDROP_D);
    max_hit   = (len_inc == MAX_LEN_D);
    term      = xdrop_hit || max_hit || in_last;
    if (xdrop_hit) begin
      cause_nx = 2'd0;
    end else if (max_hit) begin
      cause_nx = 2'd2;
    end else begin
      cause_nx = 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = EXTEND;
        end
      end
      EXTEND: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (accept && term) begin
          state_nx = REPORT;
        end
      end
      REPORT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur        <= '0;
      len        <= '0;
      best_score <= '0;
      best_len   <= '0;
      term_cause <= '0;
    end else if (state == IDLE && start) begin
      cur        <= seed_score;
      len        <= '0;
      best_score <= seed_score;
      best_len   <= '0;
    end else if (accept) begin
      cur        <= cur_nx;
      len        <= len_inc;
      best_score <= best_nx;
      best_len   <= best_len_nx;
      if (term) begin
        term_cause <= cause_nx;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ungapped_extender.sv
// Scoreboard bench for ungapped_extender (XDROP=5, MAX_LEN=8).
`default_nettype none

module tb_ungapped_extender;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] seed_score;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  cmp_result;
  logic        in_last;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] best_score;
  logic [9:0]  best_len;
  logic [1:0]  term_cause;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int score;
    int len;
    int cause;
  } rec_t;

  rec_t exp_q[$];

  localparam logic [2:0] M = 3'b001;
  localparam logic [2:0] X = 3'b010;
  localparam logic [2:0] A = 3'b100;

  always #5 clk = ~clk;

  ungapped_extender #(
    .SCORE_W(16), .LEN_W(10), .MAX_LEN(8),
    .MATCH_SCORE(1), .MISMATCH_PENALTY(3), .XDROP(5)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .seed_score(seed_score),
    .in_valid(in_valid), .in_ready(in_ready), .cmp_result(cmp_result),
    .in_last(in_last), .busy(busy), .out_valid(out_valid),
    .out_ready(out_ready), .best_score(best_score), .best_len(best_len),
    .term_cause(term_cause)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every completed record handshake is checked against the queue.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_record: got score %0d expected none",
                 $signed(best_score));
      end else begin
        rec_t e;
        e = exp_q.pop_front();
        chk("rec_score", int'($signed(best_score)), e.score);
        chk("rec_len", int'(best_len), e.len);
        chk("rec_cause", int'(term_cause), e.cause);
      end
    end
  end

  initial begin
    repeat (5000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic expect_rec(input int s, input int l, input int c);
    rec_t r;
    r.score = s; r.len = l; r.cause = c;
    exp_q.push_back(r);
  endtask

  task automatic do_start(input int seed);
    seed_score = 16'(seed);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_in_ready", int'(in_ready), 1);
    chk("start_busy", int'(busy), 1);
  endtask

  task automatic send(input logic [2:0] c, input bit last);
    in_valid = 1'b1;
    cmp_result = c;
    in_last = last;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  // Called one cycle after the terminating accept, with out_ready high.
  task automatic end_check();
    chk("term_out_valid", int'(out_valid), 1);
    chk("term_in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    chk("after_out_valid", int'(out_valid), 0);
    chk("after_busy", int'(busy), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; seed_score = '0; in_valid = 1'b0;
    cmp_result = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_best_score", int'(best_score), 0);
    chk("rst_best_len", int'(best_len), 0);
    chk("rst_term_cause", int'(term_cause), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // X-drop: 12,13,14,15,12,9 -> stops on 6th element
    expect_rec(15, 4, 0);
    do_start(11);
    send(M, 0); send(M, 0); send(M, 0); send(M, 0); send(X, 0); send(X, 0);
    end_check();

    // in_last after 3 matches
    expect_rec(14, 3, 1);
    do_start(11);
    send(M, 0); send(M, 0); send(M, 1);
    end_check();

    // MAX_LEN beats in_last
    expect_rec(19, 8, 2);
    do_start(11);
    for (int i = 0; i < 8; i++) send(M, i == 7);
    end_check();

    // Ambiguous base
`ifdef UNGAPPED_EXT_AMBIG_EN
    expect_rec(13, 3, 1);
`else
    expect_rec(12, 1, 1);
`endif
    do_start(11);
    send(M, 0); send(A, 0); send(M, 1);
    end_check();

    // Tie with best keeps shorter length: 12,9,10,11,12
    expect_rec(12, 1, 1);
    do_start(11);
    send(M, 0); send(X, 0); send(M, 0); send(M, 0); send(M, 1);
    end_check();

    // Drop of exactly XDROP does not terminate: 12,9,10,7
    expect_rec(12, 1, 1);
    do_start(11);
    send(M, 0); send(X, 0); send(M, 0); send(X, 1);
    end_check();

    // Positive saturation
    expect_rec(32767, 0, 1);
    do_start(32767);
    send(M, 1);
    end_check();

    // Negative saturation
    expect_rec(-32768, 0, 1);
    do_start(-32768);
    send(X, 1);
    end_check();

    // Backpressure in REPORT with start pulses
    expect_rec(14, 3, 1);
    do_start(11);
    out_ready = 1'b0;
    send(M, 0); send(M, 0); send(M, 1);
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      seed_score = 16'd100;
      chk("hold_out_valid", int'(out_valid), 1);
      chk("hold_in_ready", int'(in_ready), 0);
      chk("hold_score", int'($signed(best_score)), 14);
      chk("hold_len", int'(best_len), 3);
      @(posedge clk); #1;
    end
    start = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_out_valid", int'(out_valid), 0);
    chk("release_busy", int'(busy), 0);
    chk("release_in_ready", int'(in_ready), 0);

    // Reset during EXTEND
    do_start(11);
    send(M, 0); send(M, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_in_ready", int'(in_ready), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_best_score", int'(best_score), 0);
    chk("mid_rst_best_len", int'(best_len), 0);
    chk("mid_rst_term_cause", int'(term_cause), 0);
    expect_rec(0, 0, 1);
    do_start(0);
    send(X, 1);
    end_check();

    repeat (2) @(posedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
